// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, valid/ready holding register.
// Define UART_RX_PARITY_EN for 8E1 frames with parity checking.
module uart_rx #(
   parameter int unsigned BAUD_DIV = 868
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       uart_rx_i,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   output logic       frame_err_o,
   output logic       overrun_o,
   output logic       parity_err_o,
   output logic       busy_o
);

   localparam int unsigned CW = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

   state_t        state;
   logic          sync1, rxs, rxs_q;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          tick;
   logic          par_bad;

   assign tick = (cnt == '0);

`ifdef UART_RX_PARITY_EN
   logic par_bit;
   logic par_err;
   assign par_bad      = ^{shreg, par_bit};
   assign parity_err_o = par_err;
`else
   assign par_bad      = 1'b0;
   assign parity_err_o = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1       <= 1'b1;
         rxs         <= 1'b1;
         rxs_q       <= 1'b1;
         state       <= IDLE;
         cnt         <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         rx_data_o   <= '0;
         rx_valid_o  <= 1'b0;
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
         busy_o      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit     <= 1'b0;
         par_err     <= 1'b0;
`endif
      end else begin
         sync1       <= uart_rx_i;
         rxs         <= sync1;
         rxs_q       <= rxs;
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err     <= 1'b0;
`endif
         if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;
         if (state != IDLE) cnt <= tick ? FULL : cnt - CW'(1);

         case (state)
            IDLE: if (!rxs && rxs_q) begin
               state  <= START;
               cnt    <= HALF;
               busy_o <= 1'b1;
            end
            START: if (tick) begin
               if (!rxs) begin
                  state   <= DATA;
                  bit_cnt <= '0;
               end else begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end
            end
            DATA: if (tick) begin
               shreg   <= {rxs, shreg[7:1]};
               bit_cnt <= bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
               if (bit_cnt == 3'd7) state <= PARITY;
`else
               if (bit_cnt == 3'd7) state <= STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick) begin
               par_bit <= rxs;
               state   <= STOP;
            end
`endif
            STOP: if (tick) begin
               if (!rxs) begin
                  frame_err_o <= 1'b1;
`ifdef UART_RX_PARITY_EN
                  par_err     <= par_bad;
`endif
                  state       <= WAIT_IDLE;
               end else begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
                  if (par_bad) begin
`ifdef UART_RX_PARITY_EN
                     par_err <= 1'b1;
`endif
                  end else if (!rx_valid_o || rx_ready_i) begin
                     // a same-cycle drain overrides the clear above
                     rx_data_o  <= shreg;
                     rx_valid_o <= 1'b1;
                  end else begin
                     overrun_o <= 1'b1;
                  end
               end
            end
            // line held low after a bad stop bit must return high first
            WAIT_IDLE: if (rxs) begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at BAUD_DIV=16: directed table, corner sequences
// and a randomized frame stream checked against a frame-level model.
module tb_uart_rx;
   localparam int B = 16;
`ifdef UART_RX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   // edge of the stop-bit sample, counted in clocks from the start-bit line edge
   localparam int SS = B / 2 + 3 + B * (NB - 1);

   typedef logic [7:0] u8;

   logic clk = 1'b0, rst_n = 1'b0, line = 1'b1, ready = 1'b0;
   u8    rx_data;
   logic rx_valid, frame_err, overrun, parity_err, busy;

   always #5 clk = ~clk;

   uart_rx #(.BAUD_DIV(B)) dut (
      .clk_i(clk), .rst_ni(rst_n), .uart_rx_i(line),
      .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(ready),
      .frame_err_o(frame_err), .overrun_o(overrun), .parity_err_o(parity_err),
      .busy_o(busy)
   );

   int n_chk = 0, n_pass = 0;
   u8  got[$];
   int n_fe, n_ov, n_pe, n_vcyc, n_bcyc, n_unstable = 0;
   logic pv = 1'b0, pr = 1'b0;
   u8    pd = '0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid && ready) got.push_back(rx_data);
         if (rx_valid) n_vcyc++;
         if (busy) n_bcyc++;
         if (frame_err) n_fe++;
         if (overrun) n_ov++;
         if (parity_err) n_pe++;
         if (pv && !pr && rx_valid && rx_data != pd) n_unstable++;
         pv = rx_valid; pr = ready; pd = rx_data;
      end else begin
         pv = 1'b0;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic clr();
      got.delete();
      n_fe = 0; n_ov = 0; n_pe = 0; n_vcyc = 0; n_bcyc = 0;
   endtask

   // leaves the line at the stop-bit level
   task automatic send(input u8 d, input bit stop, input bit pflip);
      line = 1'b0; tick(B);
      for (int i = 0; i < 8; i++) begin line = d[i]; tick(B); end
`ifdef UART_RX_PARITY_EN
      line = (^d) ^ pflip; tick(B);
`endif
      line = stop; tick(B);
   endtask

   function automatic int first(input int idx);
      return (got.size() > idx) ? int'(got[idx]) : -1;
   endfunction

   typedef struct {
      u8  d; bit stop; bit pflip; int hold;
      int exp_x; u8 exp_d; int exp_fe; int exp_pe;
   } vec_t;
   vec_t tbl[$];

   u8  exp_q[$];
   u8  exp3[3];
   int efe, epe;

   initial begin
      tbl.push_back('{8'hA5, 1'b1, 1'b0,  0, 1, 8'hA5, 0, 0});
      tbl.push_back('{8'h5A, 1'b0, 1'b0, 40, 0, 8'h00, 1, 0});
      tbl.push_back('{8'h3C, 1'b1, 1'b0,  0, 1, 8'h3C, 0, 0});
      tbl.push_back('{8'h00, 1'b1, 1'b0,  0, 1, 8'h00, 0, 0});
      tbl.push_back('{8'hFF, 1'b1, 1'b0,  0, 1, 8'hFF, 0, 0});
`ifdef UART_RX_PARITY_EN
      tbl.push_back('{8'h03, 1'b1, 1'b0,  0, 1, 8'h03, 0, 0});
      tbl.push_back('{8'h07, 1'b1, 1'b1,  0, 0, 8'h00, 0, 1});
      tbl.push_back('{8'h07, 1'b0, 1'b1, 10, 0, 8'h00, 1, 1});
`endif

      // reset state
      tick(3);
      chk("rst_valid", rx_valid, 0);
      chk("rst_data", rx_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_flags", {frame_err, overrun, parity_err}, 0);
      rst_n = 1'b1;
      tick(4);

      // directed table
      ready = 1'b1;
      foreach (tbl[k]) begin
         clr();
         send(tbl[k].d, tbl[k].stop, tbl[k].pflip);
         tick(tbl[k].hold);
         line = 1'b1;
         tick(3 * B);
         chk($sformatf("vec%0d_xfers", k), got.size(), tbl[k].exp_x);
         if (tbl[k].exp_x > 0) chk($sformatf("vec%0d_data", k), first(0), tbl[k].exp_d);
         chk($sformatf("vec%0d_vcyc", k), n_vcyc, tbl[k].exp_x);
         chk($sformatf("vec%0d_ferr", k), n_fe, tbl[k].exp_fe);
         chk($sformatf("vec%0d_perr", k), n_pe, tbl[k].exp_pe);
         chk($sformatf("vec%0d_ovr", k), n_ov, 0);
         chk($sformatf("vec%0d_busy", k), busy, 0);
      end

      // glitch: 3 low clocks, START lasts exactly 8 cycles then back to IDLE
      clr();
      line = 1'b0; tick(3); line = 1'b1; tick(30);
      chk("glitch_busy_cycles", n_bcyc, 8);
      chk("glitch_busy_end", busy, 0);
      chk("glitch_no_valid", n_vcyc, 0);
      chk("glitch_flags", n_fe + n_ov + n_pe, 0);

      // overrun: second byte dropped, first retained
      ready = 1'b0; clr();
      send(8'h11, 1'b1, 1'b0);
      send(8'h22, 1'b1, 1'b0);
      line = 1'b1; tick(2 * B);
      chk("ovr_valid", rx_valid, 1);
      chk("ovr_data", rx_data, 8'h11);
      chk("ovr_pulse", n_ov, 1);
      chk("ovr_no_xfer", got.size(), 0);
      ready = 1'b1; tick(1); ready = 1'b0; tick(2);
      chk("ovr_drain", first(0), 8'h11);
      chk("ovr_valid_drop", rx_valid, 0);

      // back-to-back with a drain on the exact cycle of the second load
      clr();
      fork
         begin
            send(8'h00, 1'b1, 1'b0);
            send(8'hFF, 1'b1, 1'b0);
            send(8'h80, 1'b1, 1'b0);
            line = 1'b1;
         end
         begin
            tick(NB * B + SS - 1);
            ready = 1'b1; tick(1); ready = 1'b0;
            @(negedge clk);
            chk("drain_keep_valid", rx_valid, 1);
            chk("drain_new_data", rx_data, 8'hFF);
            @(posedge clk); #1;
            ready = 1'b1;
         end
      join
      tick(2 * B);
      exp3[0] = 8'h00; exp3[1] = 8'hFF; exp3[2] = 8'h80;
      chk("b2b_count", got.size(), 3);
      for (int i = 0; i < 3; i++) chk($sformatf("b2b_byte%0d", i), first(i), exp3[i]);
      chk("b2b_ovr", n_ov, 0);

      // reset mid-byte with a byte still held
      ready = 1'b0; clr();
      send(8'h55, 1'b1, 1'b0);
      line = 1'b1; tick(B);
      line = 1'b0; tick(30);
      rst_n = 1'b0; line = 1'b1; tick(3);
      chk("mrst_valid", rx_valid, 0);
      chk("mrst_data", rx_data, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_flags", {frame_err, overrun, parity_err}, 0);
      rst_n = 1'b1; tick(B);
      ready = 1'b1; clr();
      send(8'h42, 1'b1, 1'b0);
      line = 1'b1; tick(3 * B);
      chk("mrst_next_count", got.size(), 1);
      chk("mrst_next_data", first(0), 8'h42);

      // randomized stream against a frame-level model
      clr(); exp_q.delete(); efe = 0; epe = 0;
      for (int f = 0; f < 16; f++) begin
         u8  d;
         bit stop, pflip;
         d     = u8'($urandom);
         stop  = ($urandom_range(5) != 0);
         pflip = 1'b0;
`ifdef UART_RX_PARITY_EN
         pflip = ($urandom_range(5) == 0);
`endif
         send(d, stop, pflip);
         if (!stop) efe++;
         if (pflip) epe++;
         if (stop && !pflip) exp_q.push_back(d);
         line = 1'b1;
         tick(stop ? int'($urandom_range(20)) : B + int'($urandom_range(20)));
      end
      tick(3 * B);
      chk("rnd_count", got.size(), exp_q.size());
      foreach (exp_q[i]) chk($sformatf("rnd_byte%0d", i), first(i), exp_q[i]);
      chk("rnd_ferr", n_fe, efe);
      chk("rnd_perr", n_pe, epe);
      chk("rnd_ovr", n_ov, 0);
      chk("data_stable", n_unstable, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
